// File: rtl/dht11_scheduler_if.sv
// Reader-side handshake between the DHT11 scheduler and the single-wire reader.
//   meas_start : one-cycle start pulse to the reader
//   meas_abort : one-cycle pulse telling the reader to drop a stalled read
//   meas_done  : one-cycle completion pulse from the reader
//   meas_ok    : checksum good, qualified by meas_done
//   meas_hum   : humidity byte, qualified by meas_done & meas_ok
//   meas_temp  : temperature byte, qualified by meas_done & meas_ok
// master = scheduler side, slave = reader side.
interface dht11_scheduler_if;
  logic       meas_start;
  logic       meas_abort;
  logic       meas_done;
  logic       meas_ok;
  logic [7:0] meas_hum;
  logic [7:0] meas_temp;

  modport master (
    output meas_start,
    output meas_abort,
    input  meas_done,
    input  meas_ok,
    input  meas_hum,
    input  meas_temp
  );

  modport slave (
    input  meas_start,
    input  meas_abort,
    output meas_done,
    output meas_ok,
    output meas_hum,
    output meas_temp
  );
endinterface

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler.
// Decides when a reader transaction starts, enforces the minimum gap between
// starts, aborts stalled reads, retries failures and arbitrates the sensor
// between two level requesters and a periodic auto-trigger.
//   clk, reset_n        : clock, asynchronous active-low reset
//   auto_en             : enable periodic auto-trigger
//   req[1:0]            : level requests; grant is one-hot owner (0 = auto/idle)
//   ack[1:0], ack_ok    : one-cycle end-of-transaction pulse to the owner + result
//   rd                  : reader handshake (start/abort out, done/ok/data in)
//   humidity, temperature, data_valid, stale : last good reading and flags
//   err_count           : saturating count of final failures
//   busy                : state is not idle
module dht11_scheduler #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned MIN_GAP_MS = 2000,
  parameter int unsigned PERIOD_MS  = 3000,
  parameter int unsigned TIMEOUT_MS = 30,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     auto_en,
  input  logic [1:0]               req,
  output logic [1:0]               grant,
  output logic [1:0]               ack,
  output logic                     ack_ok,
  dht11_scheduler_if.master        rd,
  output logic [7:0]               humidity,
  output logic [7:0]               temperature,
  output logic                     data_valid,
  output logic                     stale,
  output logic [7:0]               err_count,
  output logic                     busy
);

  localparam int unsigned TickDiv = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PreW    = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam int unsigned GapW    = (MIN_GAP_MS > 0) ? $clog2(MIN_GAP_MS + 1) : 1;
  localparam int unsigned PerW    = (PERIOD_MS > 0) ? $clog2(PERIOD_MS + 1) : 1;
  localparam int unsigned ToW     = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam int unsigned RetW    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {StIdle, StGap, StStart, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   presc_q;
  logic [GapW-1:0]   gap_q;
  logic [PerW-1:0]   period_q;
  logic [ToW-1:0]    to_q;
  logic [RetW-1:0]   retry_q;
  logic              last_q;
  logic [1:0]        grant_q;
  logic              result_q;
  logic [7:0]        hum_q, temp_q, err_q;
  logic              valid_q, stale_q, busy_q;

  logic       tick, gap_full, period_full, timed_out, can_retry;
  logic       wait_ok, wait_fail, final_fail;
  logic [1:0] pick;

  assign tick        = (presc_q == PreW'(TickDiv - 1));
  assign gap_full    = (gap_q == GapW'(MIN_GAP_MS));
  assign period_full = (period_q == PerW'(PERIOD_MS));
  assign timed_out   = (to_q == ToW'(TIMEOUT_MS));
  assign can_retry   = (retry_q < RetW'(MAX_RETRY));

  // A done pulse in the timeout cycle wins over the timeout.
  assign wait_ok    = (state_q == StWait) & rd.meas_done & rd.meas_ok;
  assign wait_fail  = (state_q == StWait) &
                      ((rd.meas_done & ~rd.meas_ok) | (~rd.meas_done & timed_out));
  assign final_fail = wait_fail & ~can_retry;

  // Round-robin on a tie: last_q holds the index granted last.
  always_comb begin
    pick = req;
    if (req == 2'b11) pick = last_q ? 2'b01 : 2'b10;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if ((|req) || period_full) state_d = StGap;
      StGap:   if (gap_full) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (wait_ok) state_d = StDone;
        else if (wait_fail) state_d = can_retry ? StGap : StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    rd.meas_start = (state_q == StStart);
    rd.meas_abort = (state_q == StWait) & ~rd.meas_done & timed_out;
    ack           = (state_q == StDone) ? grant_q : 2'b00;
    ack_ok        = (state_q == StDone) & (|grant_q) & result_q;
  end

  // Timing counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      gap_q    <= GapW'(MIN_GAP_MS);
      period_q <= '0;
      to_q     <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;

      if (state_q == StStart) gap_q <= '0;
      else if (tick && !gap_full) gap_q <= gap_q + 1'b1;

      // Auto period only runs while idle and restarts from every completion.
      if (state_q == StDone) period_q <= '0;
      else if (state_q == StIdle) begin
        if (!auto_en) period_q <= '0;
        else if (tick && !period_full) period_q <= period_q + 1'b1;
      end

      if (state_q == StStart) to_q <= '0;
      else if ((state_q == StWait) && tick && !timed_out) to_q <= to_q + 1'b1;
    end
  end

  // Transaction bookkeeping and published results
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_q  <= '0;
      last_q   <= 1'b1;
      grant_q  <= 2'b00;
      result_q <= 1'b0;
      hum_q    <= '0;
      temp_q   <= '0;
      valid_q  <= 1'b0;
      stale_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      if ((state_q == StIdle) && (|req)) begin
        grant_q <= pick;
        last_q  <= pick[1];
      end else if (state_q == StDone) begin
        grant_q <= 2'b00;
      end

      if (state_q == StDone) retry_q <= '0;
      else if (wait_fail && can_retry) retry_q <= retry_q + 1'b1;

      if (wait_ok) begin
        result_q <= 1'b1;
        hum_q    <= rd.meas_hum;
        temp_q   <= rd.meas_temp;
        valid_q  <= 1'b1;
        stale_q  <= 1'b0;
      end else if (final_fail) begin
        result_q <= 1'b0;
        stale_q  <= valid_q;
        if (err_q != 8'hff) err_q <= err_q + 1'b1;
      end
    end
  end

  assign grant       = grant_q;
  assign humidity    = hum_q;
  assign temperature = temp_q;
  assign data_valid  = valid_q;
  assign stale       = stale_q;
  assign err_count   = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Bench for dht11_scheduler: directed vector table, hand-written auto-trigger
// and reset sequences, then randomized transactions against a
// transaction-level model of the scheduling rules.
module tb_dht11_scheduler;

  localparam int unsigned ClkHz     = 1000;
  localparam int unsigned MinGap    = 4;
  localparam int unsigned PeriodMs  = 20;
  localparam int unsigned TimeoutMs = 6;
  localparam int unsigned MaxRetry  = 2;
  // A start at cycle s lets the next GAP exit no earlier than s + GapLead.
  localparam int GapLead  = MinGap + 1;
  // With a tick every cycle the timeout fires this many cycles after start.
  localparam int AbortLag = TimeoutMs + 1;

  // Response kinds for one attempt
  localparam int KOk = 0, KBad = 1, KNone = 2, KOkAtTo = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       auto_en = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] grant, ack;
  logic       ack_ok, data_valid, stale, busy;
  logic [7:0] humidity, temperature, err_count;

  dht11_scheduler_if rd_if ();

  dht11_scheduler #(
    .CLK_HZ     (ClkHz),
    .MIN_GAP_MS (MinGap),
    .PERIOD_MS  (PeriodMs),
    .TIMEOUT_MS (TimeoutMs),
    .MAX_RETRY  (MaxRetry)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .auto_en     (auto_en),
    .req         (req),
    .grant       (grant),
    .ack         (ack),
    .ack_ok      (ack_ok),
    .rd          (rd_if),
    .humidity    (humidity),
    .temperature (temperature),
    .data_valid  (data_valid),
    .stale       (stale),
    .err_count   (err_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state
  int         last_start = -1000;
  logic       m_last = 1'b1;
  logic [7:0] m_hum = '0, m_temp = '0;
  logic       m_valid = 1'b0, m_stale = 1'b0;
  int         m_err = 0;

  // Reader emulation and drive plan
  int         done_cyc = -1;
  logic       done_ok = 1'b0;
  logic [7:0] done_h = '0, done_t = '0;
  logic [1:0] drv_req = 2'b00;
  logic       drv_auto = 1'b0;
  logic [1:0] cap_grant;
  logic       cap_ok;

  typedef struct {
    logic [1:0] rq;
    bit         cont;
    bit         drop;
    int         k0, k1, k2;
    int         d0, d1, d2;
    logic [7:0] h, t;
    logic [1:0] e_grant;
    bit         e_ok;
    int         e_err;
    bit         e_stale;
    logic [7:0] e_hum;
  } vec_t;

  vec_t vecs[9];

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // Advance one cycle: drive inputs just after the edge, return at the negedge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    req     = drv_req;
    auto_en = drv_auto;
    rd_if.meas_done = (cyc == done_cyc);
    rd_if.meas_ok   = (cyc == done_cyc) ? done_ok : 1'($urandom);
    rd_if.meas_hum  = (cyc == done_cyc) ? done_h : 8'($urandom);
    rd_if.meas_temp = (cyc == done_cyc) ? done_t : 8'($urandom);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_ack"}, int'(ack), 0);
    chk({tag, "_ack_ok"}, int'(ack_ok), 0);
    chk({tag, "_start"}, int'(rd_if.meas_start), 0);
    chk({tag, "_abort"}, int'(rd_if.meas_abort), 0);
    chk({tag, "_hum"}, int'(humidity), 0);
    chk({tag, "_temp"}, int'(temperature), 0);
    chk({tag, "_valid"}, int'(data_valid), 0);
    chk({tag, "_stale"}, int'(stale), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  // One transaction. dec is the idle cycle in which the DUT sees the trigger.
  task automatic txn(input logic [1:0] rq, input int dec, input bit drop,
                     input int k0, input int k1, input int k2,
                     input int d0, input int d1, input int d2,
                     input logic [7:0] h, input logic [7:0] t);
    int kd[3];
    int dl[3];
    int att, st_exp, ab_exp, fin;
    bit res, ended, in_txn;
    logic [1:0] owner, exp_ack;
    kd = '{k0, k1, k2};
    dl = '{d0, d1, d2};
    if (rq == 2'b00) owner = 2'b00;
    else if (rq == 2'b11) owner = m_last ? 2'b01 : 2'b10;
    else owner = rq;
    if (rq != 2'b00) m_last = (owner == 2'b10);
    done_cyc = -1;
    att = 0; ab_exp = -1; fin = -1; res = 0; ended = 0;
    st_exp = imax(dec + 1, last_start + GapLead) + 1;
    cap_grant = 2'b00; cap_ok = 1'b0;
    for (int n = 0; n < 400 && !ended; n++) begin
      if (drop && cyc >= dec) drv_req = 2'b00;
      step();
      chk("meas_start", int'(rd_if.meas_start), int'(cyc == st_exp));
      chk("meas_abort", int'(rd_if.meas_abort), int'(cyc == ab_exp));
      in_txn = (cyc > dec) && (fin < 0 || cyc <= fin + 1);
      chk("grant", int'(grant), in_txn ? int'(owner) : 0);
      chk("busy", int'(busy), int'(in_txn));
      exp_ack = (fin >= 0 && cyc == fin + 1) ? owner : 2'b00;
      chk("ack", int'(ack), int'(exp_ack));
      if (exp_ack != 2'b00) begin
        chk("ack_ok", int'(ack_ok), int'(res));
        cap_ok = ack_ok;
      end
      if (cyc == dec + 1) cap_grant = grant;
      if (cyc == st_exp) begin
        last_start = cyc;
        if (kd[att] == KNone) ab_exp = cyc + AbortLag;
        else begin
          done_cyc = cyc + ((kd[att] == KOkAtTo) ? AbortLag : dl[att]);
          done_ok  = (kd[att] != KBad);
          done_h   = h;
          done_t   = t;
        end
      end else if (fin < 0 && (cyc == done_cyc || cyc == ab_exp)) begin
        if (cyc == done_cyc && done_ok) begin
          res = 1; fin = cyc;
          m_hum = h; m_temp = t; m_valid = 1'b1; m_stale = 1'b0;
        end else if (att < int'(MaxRetry)) begin
          att++;
          ab_exp = -1;
          st_exp = imax(cyc + 1, last_start + GapLead) + 1;
        end else begin
          res = 0; fin = cyc;
          m_stale = m_valid;
          if (m_err < 255) m_err++;
        end
      end
      if (fin >= 0 && cyc == fin + 2) begin
        chk("humidity", int'(humidity), int'(m_hum));
        chk("temperature", int'(temperature), int'(m_temp));
        chk("data_valid", int'(data_valid), int'(m_valid));
        chk("stale", int'(stale), int'(m_stale));
        chk("err_count", int'(err_count), m_err);
        ended = 1;
      end
    end
    if (!ended) chk("txn_end", 0, 1);
    done_cyc = -1;
  endtask

  initial begin
    rd_if.meas_done = 1'b0;
    rd_if.meas_ok   = 1'b0;
    rd_if.meas_hum  = '0;
    rd_if.meas_temp = '0;

    vecs[0] = '{2'b01, 0, 1, KOk,  KOk,  KOk,  3, 1, 1, 8'h37, 8'h19, 2'b01, 1, 0, 0, 8'h37};
    vecs[1] = '{2'b11, 0, 0, KOk,  KOk,  KOk,  2, 1, 1, 8'h40, 8'h15, 2'b10, 1, 0, 0, 8'h40};
    vecs[2] = '{2'b11, 1, 0, KOk,  KOk,  KOk,  5, 1, 1, 8'h41, 8'h16, 2'b01, 1, 0, 0, 8'h41};
    vecs[3] = '{2'b11, 1, 1, KOk,  KOk,  KOk,  1, 1, 1, 8'h42, 8'h17, 2'b10, 1, 0, 0, 8'h42};
    vecs[4] = '{2'b01, 0, 1, KBad, KBad, KBad, 2, 4, 1, 8'haa, 8'hbb, 2'b01, 0, 1, 1, 8'h42};
    vecs[5] = '{2'b10, 0, 1, KNone, KOk, KOk,  1, 3, 1, 8'h50, 8'h20, 2'b10, 1, 1, 0, 8'h50};
    vecs[6] = '{2'b01, 0, 1, KOkAtTo, KOk, KOk, 1, 1, 1, 8'h51, 8'h21, 2'b01, 1, 1, 0, 8'h51};
    vecs[7] = '{2'b10, 0, 1, KNone, KNone, KNone, 1, 1, 1, 8'hcc, 8'hdd, 2'b10, 0, 2, 1, 8'h51};
    vecs[8] = '{2'b10, 0, 1, KBad, KNone, KOk, 3, 1, 6, 8'h52, 8'h22, 2'b10, 1, 2, 0, 8'h52};

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    reset_n = 1'b1;

    // A done pulse while idle must be ignored
    done_cyc = cyc + 1; done_ok = 1'b1; done_h = 8'h99; done_t = 8'h88;
    step();
    step();
    done_cyc = -1;
    chk("idle_done_hum", int'(humidity), 0);
    chk("idle_done_valid", int'(data_valid), 0);
    chk("idle_done_busy", int'(busy), 0);

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      int dec;
      if (vecs[i].cont) dec = cyc;
      else begin
        drv_req = vecs[i].rq;
        dec = cyc + 1;
      end
      txn(vecs[i].rq, dec, vecs[i].drop, vecs[i].k0, vecs[i].k1, vecs[i].k2,
          vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].h, vecs[i].t);
      chk("vec_grant", int'(cap_grant), int'(vecs[i].e_grant));
      chk("vec_ack_ok", int'(cap_ok), int'(vecs[i].e_ok));
      chk("vec_err", int'(err_count), vecs[i].e_err);
      chk("vec_stale", int'(stale), int'(vecs[i].e_stale));
      chk("vec_hum", int'(humidity), int'(vecs[i].e_hum));
    end

    // Auto trigger: fires after PeriodMs idle ticks, no owner, no ack
    drv_auto = 1'b1;
    begin
      int a;
      a = cyc + 1;
      txn(2'b00, a + int'(PeriodMs), 1'b1, KOk, KOk, KOk, 2, 1, 1, 8'h60, 8'h23);
      chk("auto_grant", int'(cap_grant), 0);
    end

    // A request in the same cycle the period expires takes the transaction
    for (int i = 0; i < int'(PeriodMs) - 1; i++) begin
      step();
      chk("auto_wait_busy", int'(busy), 0);
    end
    drv_req = 2'b01;
    txn(2'b01, cyc + 1, 1'b1, KOk, KOk, KOk, 4, 1, 1, 8'h61, 8'h24);
    chk("req_beats_auto", int'(cap_grant), 1);
    chk("req_beats_auto_ok", int'(cap_ok), 1);
    drv_auto = 1'b0;

    // Randomized transactions against the model
    begin
      bit held;
      bit hold;
      logic [1:0] rq;
      int dec;
      held = 0;
      rq = 2'b01;
      for (int n = 0; n < 40; n++) begin
        if (!held) rq = 2'($urandom_range(3, 1));
        hold = (n < 39) && ($urandom_range(3, 0) == 0);
        if (held) dec = cyc;
        else begin
          drv_req = rq;
          dec = cyc + 1;
        end
        txn(rq, dec, !hold,
            int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
            int'($urandom_range(6, 1)), int'($urandom_range(6, 1)), int'($urandom_range(6, 1)),
            8'($urandom), 8'($urandom));
        held = hold;
      end
    end

    // Asynchronous reset while waiting on the reader
    repeat (8) step();
    drv_req = 2'b01;
    step();
    drv_req = 2'b00;
    step();
    step();
    chk("pre_reset_start", int'(rd_if.meas_start), 1);
    step();
    step();
    chk("pre_reset_busy", int'(busy), 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    step();
    step();
    reset_n = 1'b1;
    last_start = -1000; m_last = 1'b1; m_hum = '0; m_temp = '0;
    m_valid = 1'b0; m_stale = 1'b0; m_err = 0;
    drv_req = 2'b01;
    txn(2'b01, cyc + 1, 1'b1, KOk, KOk, KOk, 2, 1, 1, 8'h33, 8'h12);
    chk("post_reset_grant", int'(cap_grant), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
